// File: rtl/lsu_controller.sv
// lsu_controller
//   Load/store unit bus sequencer for the memory stage. An aligned load or
//   store is captured in IDLE and issued on a simple request/grant bus. The
//   pipeline is stalled while the access is in flight. A store finishes on
//   grant. A load finishes when read data returns, and the data is then
//   formatted by width and sign. A watchdog counter aborts an access that
//   the bus never finishes and reports it as a bus error.
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset
//     mem_rd, mem_wr    : memory-stage load / store strobe (both set = store)
//     load_type         : 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu (others = lw)
//     store_type        : 00 sw, 01 sh, 10 sb
//     addr, wdata       : byte address and rs2 store data
//     bus_req, bus_we   : bus request and write enable
//     bus_addr, bus_be  : word-aligned address and byte enables
//     bus_wdata         : lane-replicated store data
//     bus_gnt           : bus accepted the request
//     bus_rvalid        : read data valid
//     bus_rdata         : read data
//     stall             : pipeline freeze while an access is in flight
//     done              : one-cycle completion pulse
//     load_data         : formatted load result, valid with done
//     misalign          : one-cycle misaligned-access flag
//     bus_err           : one-cycle timeout flag, coincident with done
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  load_type,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [2:0] LOAD_LB   = 3'b000;
    localparam logic [2:0] LOAD_LH   = 3'b001;
    localparam logic [2:0] LOAD_LW   = 3'b010;
    localparam logic [2:0] LOAD_LBU  = 3'b011;
    localparam logic [2:0] LOAD_LHU  = 3'b100;
    localparam logic [1:0] STORE_SW  = 2'b00;
    localparam logic [1:0] STORE_SH  = 2'b01;
    localparam logic [1:0] STORE_SB  = 2'b10;

    // Counter value that marks the last permitted cycle in REQ/WAIT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic        access_s;
    logic        is_store_s;
    logic        misaligned_s;
    logic        start_s;
    logic        misalign_s;
    logic        timeout_hit_s;
    logic        take_rdata_s;
    logic        timeout_s;

    logic        is_store_r;
    logic [2:0]  load_type_r;
    logic [1:0]  offset_r;
    logic [7:0]  timeout_cnt_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;
    logic        stall_r;
    logic        done_r;
    logic        bus_err_r;
    logic [31:0] load_data_r;

    // True when the access would cross its natural size boundary.
    function automatic logic access_misaligned(
        input logic       store,
        input logic [2:0] ltype,
        input logic [1:0] stype,
        input logic [1:0] off
    );
        logic mis;
        if (store) begin
            case (stype)
                STORE_SB: mis = 1'b0;
                STORE_SH: mis = off[0];
                default:  mis = (off != 2'b00);
            endcase
        end else begin
            case (ltype)
                LOAD_LB, LOAD_LBU: mis = 1'b0;
                LOAD_LH, LOAD_LHU: mis = off[0];
                default:           mis = (off != 2'b00);
            endcase
        end
        return mis;
    endfunction

    // Byte enables for a store of the given width at the given lane offset.
    function automatic logic [3:0] store_be(
        input logic [1:0] stype,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (stype)
            STORE_SB: be = 4'b0001 << off;
            STORE_SH: be = off[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across every lane it could land on.
    function automatic logic [31:0] store_lanes(
        input logic [1:0]  stype,
        input logic [31:0] data
    );
        logic [31:0] lanes;
        case (stype)
            STORE_SB: lanes = {4{data[7:0]}};
            STORE_SH: lanes = {2{data[15:0]}};
            default:  lanes = data;
        endcase
        return lanes;
    endfunction

    // Pick the addressed byte/halfword out of a bus word and extend it.
    function automatic logic [31:0] format_load(
        input logic [2:0]  ltype,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (off)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (ltype)
            LOAD_LB:  res = {{24{byte_v[7]}}, byte_v};
            LOAD_LH:  res = {{16{half_v[15]}}, half_v};
            LOAD_LBU: res = {24'h00_0000, byte_v};
            LOAD_LHU: res = {16'h0000, half_v};
            LOAD_LW:  res = word;
            default:  res = word;
        endcase
        return res;
    endfunction

    // A simultaneous load and store strobe is resolved as a store.
    assign access_s      = ~rst & (mem_rd | mem_wr);
    assign is_store_s    = mem_wr;
    assign misaligned_s  = access_misaligned(is_store_s, load_type, store_type, addr[1:0]);
    assign timeout_hit_s = (timeout_cnt_r == TIMEOUT_LAST);

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        misalign_s   = 1'b0;
        take_rdata_s = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    if (misaligned_s) begin
                        misalign_s   = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        start_s      = 1'b1;
                        next_state_s = REQ;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                // A grant in the timeout cycle still wins.
                if (bus_gnt) begin
                    next_state_s = is_store_r ? DONE : WAIT;
                end else if (timeout_hit_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    take_rdata_s = 1'b1;
                    next_state_s = DONE;
                end else if (timeout_hit_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture, bus drive, watchdog counter and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_r    <= 1'b0;
            load_type_r   <= 3'b000;
            offset_r      <= 2'b00;
            timeout_cnt_r <= 8'd0;
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= 32'h0000_0000;
            bus_be_r      <= 4'b0000;
            bus_wdata_r   <= 32'h0000_0000;
            stall_r       <= 1'b0;
            done_r        <= 1'b0;
            bus_err_r     <= 1'b0;
            load_data_r   <= 32'h0000_0000;
        end else begin
            bus_req_r <= (next_state_s == REQ);
            stall_r   <= (next_state_s == REQ) || (next_state_s == WAIT);
            done_r    <= (next_state_s == DONE);
            bus_err_r <= timeout_s;

            // Bus fields are frozen at issue so they stay stable through REQ.
            if (start_s) begin
                is_store_r  <= is_store_s;
                load_type_r <= load_type;
                offset_r    <= addr[1:0];
                bus_addr_r  <= {addr[31:2], 2'b00};
                bus_we_r    <= is_store_s;
                bus_be_r    <= is_store_s ? store_be(store_type, addr[1:0]) : 4'b1111;
                bus_wdata_r <= is_store_s ? store_lanes(store_type, wdata) : 32'h0000_0000;
            end

            if (start_s) begin
                timeout_cnt_r <= 8'd0;
            end else if ((state_r == REQ) || (state_r == WAIT)) begin
                timeout_cnt_r <= timeout_cnt_r + 8'd1;
            end

            if (take_rdata_s) begin
                load_data_r <= format_load(load_type_r, offset_r, bus_rdata);
            end else if (timeout_s) begin
                load_data_r <= 32'h0000_0000;
            end
        end
    end

    // Stall rises in the issue cycle itself so the pipeline freezes with the
    // instruction; misalign is reported in that same cycle for the same reason.
    assign stall     = start_s | (stall_r & ~rst);
    assign misalign  = misalign_s;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;
    assign done      = done_r;
    assign bus_err   = bus_err_r;
    assign load_data = load_data_r;

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller
//   Randomised transaction-level bench for lsu_controller. Two instances are
//   used: one with the default watchdog and one with a 4-cycle watchdog. Each
//   transaction's expected bus fields, timing and load result are computed
//   from access size, offset and bus delays with plain arithmetic.
module tb_lsu_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a;
    logic        rst_b;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic        a_bus_req, a_bus_we, a_stall, a_done, a_misalign, a_bus_err;
    logic [31:0] a_bus_addr, a_bus_wdata, a_load_data;
    logic [3:0]  a_bus_be;
    logic        b_bus_req, b_bus_we, b_stall, b_done, b_misalign, b_bus_err;
    logic [31:0] b_bus_addr, b_bus_wdata, b_load_data;
    logic [3:0]  b_bus_be;

    // Selects which instance the checks observe.
    logic        use_b;
    logic        o_bus_req, o_bus_we, o_stall, o_done, o_misalign, o_bus_err;
    logic [31:0] o_bus_addr, o_bus_wdata, o_load_data;
    logic [3:0]  o_bus_be;

    assign o_bus_req   = use_b ? b_bus_req   : a_bus_req;
    assign o_bus_we    = use_b ? b_bus_we    : a_bus_we;
    assign o_stall     = use_b ? b_stall     : a_stall;
    assign o_done      = use_b ? b_done      : a_done;
    assign o_misalign  = use_b ? b_misalign  : a_misalign;
    assign o_bus_err   = use_b ? b_bus_err   : a_bus_err;
    assign o_bus_addr  = use_b ? b_bus_addr  : a_bus_addr;
    assign o_bus_wdata = use_b ? b_bus_wdata : a_bus_wdata;
    assign o_load_data = use_b ? b_load_data : a_load_data;
    assign o_bus_be    = use_b ? b_bus_be    : a_bus_be;

    lsu_controller dut_a (
        .clk(clk), .rst(rst_a), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
        .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_bus_be),
        .bus_wdata(a_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .stall(a_stall), .done(a_done), .load_data(a_load_data),
        .misalign(a_misalign), .bus_err(a_bus_err)
    );

    lsu_controller #(.TIMEOUT_CYC(4)) dut_b (
        .clk(clk), .rst(rst_b), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .load_type(load_type), .store_type(store_type), .addr(addr), .wdata(wdata),
        .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_be(b_bus_be),
        .bus_wdata(b_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .stall(b_stall), .done(b_done), .load_data(b_load_data),
        .misalign(b_misalign), .bus_err(b_bus_err)
    );

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, act, exp);
        end
    endtask

    function automatic int store_size(input logic [1:0] st);
        if (st == 2'b10) return 1;
        else if (st == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic int load_size(input logic [2:0] lt);
        if (lt == 3'b000 || lt == 3'b011) return 1;
        else if (lt == 3'b001 || lt == 3'b100) return 2;
        else return 4;
    endfunction

    // Reference load result: shift the addressed item down, mask, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] lt, input int off, input logic [31:0] d);
        longint v;
        int     sz;
        bit     sgn;
        sz  = load_size(lt);
        sgn = (lt == 3'b000) || (lt == 3'b001);
        if (sz == 4) return d;
        v = longint'((d >> (8 * off)) & ((32'd1 << (8 * sz)) - 32'd1));
        if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic drive_req(input bit is_st, input bit both, input logic [2:0] lt,
                             input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd);
        mem_wr     = is_st;
        mem_rd     = !is_st || both;
        load_type  = lt;
        store_type = st;
        addr       = a;
        wdata      = wd;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr       = $urandom;
        bus_gnt    = 1'($urandom);
        bus_rvalid = 1'($urandom);
        bus_rdata  = $urandom;
        @(negedge clk);
        check_eq("idle_stall",    32'(o_stall),    32'd0);
        check_eq("idle_bus_req",  32'(o_bus_req),  32'd0);
        check_eq("idle_done",     32'(o_done),     32'd0);
        check_eq("idle_misalign", 32'(o_misalign), 32'd0);
        check_eq("idle_bus_err",  32'(o_bus_err),  32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_bus_req"},   32'(o_bus_req),  32'd0);
        check_eq({tag, "_bus_we"},    32'(o_bus_we),   32'd0);
        check_eq({tag, "_bus_be"},    32'(o_bus_be),   32'd0);
        check_eq({tag, "_stall"},     32'(o_stall),    32'd0);
        check_eq({tag, "_done"},      32'(o_done),     32'd0);
        check_eq({tag, "_misalign"},  32'(o_misalign), 32'd0);
        check_eq({tag, "_bus_err"},   32'(o_bus_err),  32'd0);
        check_eq({tag, "_load_data"}, o_load_data,     32'd0);
    endtask

    // One access: g = cycles in REQ before grant, r = cycles in WAIT before rvalid.
    // Cycle 0 is the issue cycle; the watchdog window counts from cycle 1 (n = k-1).
    task automatic run_txn(input bit is_st, input bit both, input logic [2:0] lt,
                           input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd,
                           input int g, input int r, input logic [31:0] rd_val);
        int tcyc, off, size, complete_n, end_n, done_k, req_end, stalls;
        bit mis, tmo;
        logic [31:0] e_be, e_wd, e_ld;
        tcyc = use_b ? 4 : 255;
        off  = int'(a[1:0]);
        size = is_st ? store_size(st) : load_size(lt);
        mis  = (off % size) != 0;
        if (mis) begin
            @(posedge clk); #1;
            drive_req(is_st, both, lt, st, a, wd);
            bus_gnt    = 1'($urandom);
            bus_rvalid = 1'($urandom);
            @(negedge clk);
            check_eq("misalign_pulse", 32'(o_misalign), 32'd1);
            check_eq("misalign_stall", 32'(o_stall),    32'd0);
            check_eq("misalign_req",   32'(o_bus_req),  32'd0);
            idle_cycle();
        end else begin
            e_be = (size == 1) ? (32'd1 << off) : (size == 2) ? (32'd3 << off) : 32'd15;
            e_wd = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                   (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
            e_ld = model_load(lt, off, rd_val);
            complete_n = is_st ? g : g + 1 + r;
            if (is_st) tmo = g > tcyc - 1;
            else       tmo = (g > tcyc - 1) || (g < tcyc - 1 && complete_n > tcyc - 1);
            end_n   = tmo ? tcyc - 1 : complete_n;
            req_end = (g > tcyc - 1) ? tcyc - 1 : g;
            done_k  = end_n + 2;
            stalls  = 0;
            for (int k = 0; k <= done_k; k++) begin
                @(posedge clk); #1;
                if (k == 0) drive_req(is_st, both, lt, st, a, wd);
                else        drive_req(is_st, both, lt, st, $urandom, $urandom);
                bus_gnt = (k == g + 1) ? 1'b1 : ((k > g + 1) ? 1'($urandom) : 1'b0);
                if (!is_st && k == g + 2 + r) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rd_val;
                end else begin
                    bus_rvalid = (k <= g + 1) ? 1'($urandom) : 1'b0;
                    bus_rdata  = $urandom;
                end
                @(negedge clk);
                if (o_stall) stalls++;
                check_eq("stall",    32'(o_stall),    32'(k < done_k));
                check_eq("bus_req",  32'(o_bus_req),  32'(k >= 1 && k <= req_end + 1));
                check_eq("done",     32'(o_done),     32'(k == done_k));
                check_eq("bus_err",  32'(o_bus_err),  32'(k == done_k && tmo));
                check_eq("misalign", 32'(o_misalign), 32'd0);
                if (k >= 1 && k <= req_end + 1) begin
                    check_eq("bus_addr", o_bus_addr,      a & 32'hFFFF_FFFC);
                    check_eq("bus_we",   32'(o_bus_we),   32'(is_st));
                    if (is_st) begin
                        check_eq("bus_be",    32'(o_bus_be), e_be);
                        check_eq("bus_wdata", o_bus_wdata,   e_wd);
                    end
                end
                if (k == done_k && (!is_st || tmo)) begin
                    check_eq("load_data", o_load_data, tmo ? 32'd0 : e_ld);
                end
            end
            check_eq("stall_count", 32'(stalls), 32'(done_k));
        end
    endtask

    task automatic random_txns(input int n, input int gmax);
        bit          is_st, both;
        logic [2:0]  lt;
        logic [1:0]  st;
        for (int i = 0; i < n; i++) begin
            is_st = 1'($urandom);
            both  = 1'($urandom);
            lt    = 3'($urandom);
            st    = 2'($urandom_range(0, 2));
            run_txn(is_st, both, lt, st, $urandom, $urandom,
                    $urandom_range(0, gmax), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        use_b      = 1'b0;
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        load_type  = 3'b000;
        store_type = 2'b00;
        addr       = 32'd0;
        wdata      = 32'd0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_a");
        use_b = 1'b1;
        #1;
        check_zero("reset_b");
        use_b = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0;

        // Directed accesses on the default-watchdog instance.
        run_txn(1'b1, 1'b0, 3'b000, 2'b10, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0);
        run_txn(1'b0, 1'b0, 3'b000, 2'b00, 32'h0000_2002, 32'd0, 0, 0, 32'h0080_0000);
        run_txn(1'b0, 1'b0, 3'b011, 2'b00, 32'h0000_2002, 32'd0, 0, 0, 32'h0080_0000);
        run_txn(1'b0, 1'b0, 3'b001, 2'b00, 32'h0000_3001, 32'd0, 0, 0, 32'd0);
        run_txn(1'b0, 1'b0, 3'b010, 2'b00, 32'h0000_4000, 32'd0, 5, 0, 32'hDEAD_BEEF);
        run_txn(1'b1, 1'b1, 3'b000, 2'b01, 32'h0000_4102, 32'h1234_8765, 1, 0, 32'd0);
        run_txn(1'b0, 1'b0, 3'b110, 2'b00, 32'h0000_4204, 32'd0, 0, 2, 32'hCAFE_F00D);

        // Reset while a load waits for data; a late rvalid must not revive it.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'b010, 2'b00, 32'h0000_5000, 32'd0);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        mem_rd = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        check_eq("wait_stall",   32'(o_stall),   32'd1);
        check_eq("wait_bus_req", 32'(o_bus_req), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check_zero("rst_in_wait");
        @(posedge clk); #1;
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check_zero("late_rvalid");
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check_zero("after_late_rvalid");

        random_txns(150, 6);

        // Switch to the 4-cycle watchdog instance.
        @(posedge clk); #1;
        rst_a  = 1'b1;
        rst_b  = 1'b0;
        use_b  = 1'b1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        run_txn(1'b0, 1'b0, 3'b010, 2'b00, 32'h0000_0100, 32'd0, 100, 0, 32'h1111_2222);
        run_txn(1'b1, 1'b0, 3'b000, 2'b00, 32'h0000_0200, 32'h5555_AAAA, 3, 0, 32'd0);
        run_txn(1'b0, 1'b0, 3'b100, 2'b00, 32'h0000_0302, 32'd0, 0, 2, 32'h8001_7FFF);
        run_txn(1'b0, 1'b0, 3'b000, 2'b00, 32'h0000_0401, 32'd0, 3, 1, 32'h0000_F000);
        run_txn(1'b0, 1'b0, 3'b100, 2'b00, 32'h0000_0500, 32'd0, 1, 3, 32'h0000_FFFF);
        run_txn(1'b1, 1'b0, 3'b000, 2'b10, 32'h0000_0600, 32'h0000_0011, 7, 0, 32'd0);

        random_txns(150, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
- REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles spent in REQ plus WAIT before a bus error is declared (range 1..255).
- REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-004 The block SHALL have port mem_rd, input, 1: the memory-stage instruction is a load.
- REQ-005 The block SHALL have port mem_wr, input, 1: the memory-stage instruction is a store.
- REQ-006 The block SHALL have port load_type, input, 3: load width and extension code: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu.
- REQ-007 The block SHALL have port store_type, input, 2: store width code: 00 sw, 01 sh, 10 sb.
- REQ-008 The block SHALL have port addr, input, 32: byte address from the ALU.
- REQ-009 The block SHALL have port wdata, input, 32: store data from rs2.
- REQ-010 The block SHALL have port bus_req, output, 1: bus request.
- REQ-011 The block SHALL have port bus_we, output, 1: bus write enable.
- REQ-012 The block SHALL have port bus_addr, output, 32: word-aligned address, {addr[31:2],2'b00}.
- REQ-013 The block SHALL have port bus_be, output, 4: byte enables.
- REQ-014 The block SHALL have port bus_wdata, output, 32: lane-replicated store data.
- REQ-015 The block SHALL have port bus_gnt, input, 1: the bus has accepted the request.
- REQ-016 The block SHALL have port bus_rvalid, input, 1: read data is valid.
- REQ-017 The block SHALL have port bus_rdata, input, 32: read data.
- REQ-018 The block SHALL have port stall, output, 1: freezes the pipeline while an access is in flight.
- REQ-019 The block SHALL have port done, output, 1: one-cycle pulse marking access completion.
- REQ-020 The block SHALL have port load_data, output, 32: formatted load result, valid when done=1.
- REQ-021 The block SHALL have port misalign, output, 1: one-cycle pulse flagging a misaligned access.
- REQ-022 The block SHALL have port bus_err, output, 1: one-cycle pulse flagging a timeout.

Function
- REQ-023 The FSM SHALL have exactly four states, IDLE, REQ, WAIT and DONE, and SHALL be in IDLE after reset.
- REQ-024 In IDLE with (mem_rd|mem_wr)=1 and an aligned address, the block SHALL latch all request inputs, drive stall=1 combinationally in that same cycle, and move to REQ.
- REQ-025 If mem_rd and mem_wr are both 1, the access SHALL be treated as a store.
- REQ-026 An access SHALL be misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]!=00.
- REQ-027 On a misaligned access in IDLE, the block SHALL pulse misalign for one cycle, keep stall=0 and bus_req=0, and stay in IDLE.
- REQ-028 In REQ, the block SHALL hold bus_req=1 with bus_addr, bus_be, bus_we and bus_wdata stable until bus_gnt=1.
- REQ-029 On bus_gnt=1 in REQ, a store SHALL go to DONE and a load SHALL go to WAIT.
- REQ-030 In WAIT, bus_req SHALL be 0; on bus_rvalid=1 the block SHALL register the formatted data into load_data and go to DONE.
- REQ-031 In DONE, the block SHALL drive done=1 and stall=0, ignore mem_rd and mem_wr, and return to IDLE.
- REQ-032 Byte enables: sb SHALL drive 1<<addr[1:0]; sh SHALL drive 0011 when addr[1]=0 and 1100 when addr[1]=1; sw SHALL drive 1111.
- REQ-033 Store data: sb SHALL replicate wdata[7:0] on all four lanes; sh SHALL replicate wdata[15:0] on both halves; sw SHALL pass wdata unchanged.
- REQ-034 Load formatting: lb/lbu SHALL select the byte at lane addr[1:0]; lh/lhu SHALL select the halfword at addr[1]; lb/lh SHALL sign-extend, lbu/lhu SHALL zero-extend, and lw SHALL pass the word unchanged.
- REQ-035 A load_type value of 101..111 SHALL be handled as lw.
- REQ-036 An 8-bit timeout counter SHALL clear on entry to REQ and increment every cycle in REQ or WAIT.
- REQ-037 When the timeout counter equals TIMEOUT_CYC-1 without completion, the block SHALL pulse bus_err, set load_data=0, and go to DONE.
- REQ-038 A bus_gnt or bus_rvalid that arrives in the same cycle as the timeout SHALL take priority: the access completes normally and no bus_err is raised.
- REQ-039 bus_rvalid SHALL be ignored outside WAIT.
- REQ-040 bus_gnt SHALL be ignored outside REQ.
- REQ-041 Minimum latency SHALL be: a store with immediate grant stalls 2 cycles with done in cycle 3; a load with immediate grant and next-cycle rvalid stalls 3 cycles with done in cycle 4.

Reset
- REQ-042 While rst=1, state SHALL be IDLE, and bus_req, bus_we, bus_be, stall, done, misalign, bus_err, load_data and the counter SHALL all be 0.
- REQ-043 A reset asserted mid-access SHALL abandon the access without completing it and drop bus_req in the next cycle.

Verification
- REQ-044 Scenario: sb with addr=0x1003, wdata=0x000000A5 and bus_gnt=1 at REQ -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, stall high for 2 cycles, then done.
- REQ-045 Scenario: lb with addr=0x2002, rdata=0x00800000 -> load_data=0xFFFFFF80; the same access as lbu -> load_data=0x00000080.
- REQ-046 Scenario: lh with addr=0x3001 -> misalign pulses for one cycle, bus_req is never asserted, and stall=0.
- REQ-047 Scenario: lw with bus_gnt delayed 5 cycles -> bus signals are stable throughout, and the total stall equals 5+3 cycles.
- REQ-048 Scenario: TIMEOUT_CYC=4 with no grant -> bus_err and done pulse together after 4 cycles in REQ, and load_data=0.
- REQ-049 Scenario: rst asserted while in WAIT -> the next cycle shows IDLE with all outputs 0, and a late rvalid has no effect.
